// File: rtl/uart_lite_pkg.sv
// ----------------------------------------------------------------------------
// uart_lite_pkg
// Shared definitions for AXI UART Lite masters: register offsets, STAT bit
// indices, the AXI OKAY response code and the result-writer FSM states.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_lite_pkg;

    // UART Lite register map (byte offsets)
    localparam logic [3:0] UART_RX_FIFO_OFFSET = 4'h0;
    localparam logic [3:0] UART_TX_FIFO_OFFSET = 4'h4;
    localparam logic [3:0] UART_STAT_OFFSET    = 4'h8;
    localparam logic [3:0] UART_CTRL_OFFSET    = 4'hC;

    // STAT register bit indices
    localparam int STAT_RX_VALID_BIT = 0;
    localparam int STAT_RX_FULL_BIT  = 1;
    localparam int STAT_TX_EMPTY_BIT = 2;
    localparam int STAT_TX_FULL_BIT  = 3;
    localparam int STAT_INTR_EN_BIT  = 4;
    localparam int STAT_OVERRUN_BIT  = 5;
    localparam int STAT_FRAME_BIT    = 6;
    localparam int STAT_PARITY_BIT   = 7;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    // Longest encoded result (ASCII: two digits plus CR LF)
    localparam int MAX_RESULT_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_STAT_AR,
        ST_STAT_R,
        ST_WR,
        ST_BRESP
    } wr_state_t;

endpackage

// File: rtl/result_formatter.sv
// ----------------------------------------------------------------------------
// result_formatter
// Combinational encoder turning a 5-bit winner ID into the byte stream sent
// to the UART. Byte 0 sits in bits [7:0] and is transmitted first.
// Build option: ASCII_RESULT_EN
//   defined   -> 4 bytes: '0'+tens, '0'+ones, CR (0x0D), LF (0x0A)
//   undefined -> 1 byte : {3'b000, winner_id}
// Ports:
//   winner_id  in  5   class ID to encode
//   bytes      out 32  encoded bytes, byte k in bits [8k+7:8k]
//   byte_count out 3   number of valid bytes (1 or 4)
// ----------------------------------------------------------------------------
module result_formatter
    import uart_lite_pkg::*;
(
    input  logic [4:0]  winner_id,
    output logic [31:0] bytes,
    output logic [2:0]  byte_count
);

`ifdef ASCII_RESULT_EN
    logic [1:0] tens;
    logic [3:0] ones;

    // IDs only reach 31, so three compares replace a divider.
    always_comb begin
        tens = 2'd0;
        ones = winner_id[3:0];
        if (winner_id >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(winner_id - 5'd30);
        end else if (winner_id >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(winner_id - 5'd20);
        end else if (winner_id >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(winner_id - 5'd10);
        end
        bytes      = {8'h0A, 8'h0D, 4'h3, ones, 6'b001100, tens};
        byte_count = 3'(MAX_RESULT_BYTES);
    end
`else
    always_comb begin
        bytes      = {24'h000000, 3'b000, winner_id};
        byte_count = 3'd1;
    end
`endif

endmodule

// File: rtl/axi_uart_result_writer.sv
// ----------------------------------------------------------------------------
// axi_uart_result_writer
// AXI4-Lite master returning each ensemble classification result to the host
// through the UART Lite TX FIFO. For every byte it requests the shared UART
// port, polls STAT until the TX FIFO is not full, writes the byte and waits
// for the write response. bus_req is dropped for at least one cycle between
// bytes so the reader sharing the port can win arbitration.
// Build option: ASCII_RESULT_EN (see result_formatter) selects ASCII output.
// Ports:
//   m_axi_aclk, m_axi_aresetn   clock, asynchronous active-low reset
//   result_valid/result_ready   result handshake, winner_ID carries the class
//   bus_req/bus_grant           request/grant to the top-level UART arbiter
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master channels
//   sent_count                  completed results (wraps)
//   axi_err                     sticky flag, any non-OKAY BRESP/RRESP
// ----------------------------------------------------------------------------
module axi_uart_result_writer
    import uart_lite_pkg::*;
#(
    parameter int              ADDR_W       = 4,
    parameter logic [ADDR_W-1:0] TX_FIFO_ADDR = ADDR_W'(UART_TX_FIFO_OFFSET),
    parameter logic [ADDR_W-1:0] STAT_ADDR    = ADDR_W'(UART_STAT_OFFSET),
    parameter int              TX_FULL_BIT  = STAT_TX_FULL_BIT,
    parameter int              CNT_W        = 16
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,

    input  logic              result_valid,
    input  logic [4:0]        winner_ID,
    output logic              result_ready,

    output logic              bus_req,
    input  logic              bus_grant,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,

    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic [CNT_W-1:0]  sent_count,
    output logic              axi_err
);

    wr_state_t   state;
    logic [31:0] fmt_bytes;
    logic [2:0]  fmt_count;
    logic [31:0] byte_buf;
    logic [2:0]  byte_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  cur_byte;
    logic        capture;
    logic        last_byte;
    logic        aw_done;
    logic        w_done;
    logic        unused_rdata;

    result_formatter u_fmt (
        .winner_id  (winner_ID),
        .bytes      (fmt_bytes),
        .byte_count (fmt_count)
    );

    // result_ready is only ever high in IDLE, so no state qualifier needed.
    assign capture   = result_valid && result_ready;
    assign cur_byte  = byte_buf[{byte_idx, 3'b000} +: 8];
    assign last_byte = (3'({1'b0, byte_idx}) + 3'd1) >= byte_cnt;

    // A channel counts as done once its valid is already low or the
    // handshake happens this cycle; AW and W may finish in any order.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    // Only the TX full bit of STAT matters here.
    assign unused_rdata = ^m_axi_rdata;

    // Byte buffer holds data only; it is qualified by the FSM state.
    always_ff @(posedge m_axi_aclk) begin
        if (capture) begin
            byte_buf <= fmt_bytes;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= ST_IDLE;
            result_ready  <= 1'b0;
            bus_req       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= 4'b0000;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            sent_count    <= '0;
            axi_err       <= 1'b0;
            byte_cnt      <= 3'd0;
            byte_idx      <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        result_ready <= 1'b0;
                        bus_req      <= 1'b1;
                        byte_cnt     <= fmt_count;
                        byte_idx     <= 2'd0;
                        state        <= ST_REQ;
                    end else begin
                        result_ready <= 1'b1;
                    end
                end

                // Entered with bus_req low between bytes: raise it one
                // cycle later so the request is visibly released.
                ST_REQ: begin
                    if (!bus_req) begin
                        bus_req <= 1'b1;
                    end else if (bus_grant) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= STAT_ADDR;
                        state         <= ST_STAT_AR;
                    end
                end

                ST_STAT_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_STAT_R;
                    end
                end

                ST_STAT_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (m_axi_rresp != AXI_OKAY) begin
                            axi_err <= 1'b1;
                        end
                        if (m_axi_rdata[TX_FULL_BIT]) begin
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_STAT_AR;
                        end else begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_awaddr  <= TX_FIFO_ADDR;
                            m_axi_wvalid  <= 1'b1;
                            m_axi_wdata   <= {24'h000000, cur_byte};
                            m_axi_wstrb   <= 4'b0001;
                            state         <= ST_WR;
                        end
                    end
                end

                ST_WR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_BRESP;
                    end
                end

                ST_BRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        bus_req      <= 1'b0;
                        if (m_axi_bresp != AXI_OKAY) begin
                            axi_err <= 1'b1;
                        end
                        if (last_byte) begin
                            sent_count   <= sent_count + 1'b1;
                            result_ready <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= ST_REQ;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_uart_result_writer.sv
// ----------------------------------------------------------------------------
// tb_axi_uart_result_writer
// Directed bench for axi_uart_result_writer with a reactive AXI4-Lite UART
// slave. Expected bytes follow ASCII_RESULT_EN when the bench is built with
// that macro defined.
// ----------------------------------------------------------------------------
module tb_axi_uart_result_writer;

`ifdef ASCII_RESULT_EN
    localparam int NB = 4;
`else
    localparam int NB = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        result_valid;
    logic [4:0]  winner_id;
    logic        result_ready;
    logic        bus_req;
    logic        bus_grant;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [15:0] sent_count;
    logic        axi_err;

    axi_uart_result_writer dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .result_valid  (result_valid),
        .winner_ID     (winner_id),
        .result_ready  (result_ready),
        .bus_req       (bus_req),
        .bus_grant     (bus_grant),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .sent_count    (sent_count),
        .axi_err       (axi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave configuration (written by the stimulus only)
    int          aw_dly;
    int          w_dly;
    int          full_base;
    int          full_limit;
    logic [1:0]  bresp_cfg;
    logic [1:0]  rresp_cfg;

    // Slave state and logs (written by the slave only)
    int          ar_n, aw_n, w_n, b_n, viol_n, req_fall_n, aw_only_n, w_only_n;
    logic [3:0]  last_araddr;
    logic [3:0]  aw_log [128];
    int          aw_ar_log [128];
    logic [31:0] wd_log [128];
    logic [3:0]  ws_log [128];

    int n_cmp;
    int n_err;
    int exp_sent;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int id, input int k);
`ifdef ASCII_RESULT_EN
        case (k)
            0:       return 8'(48 + id / 10);
            1:       return 8'(48 + id % 10);
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
`else
        return (k == 0) ? 8'(id) : 8'h00;
`endif
    endfunction

    // Reactive UART slave. Handshakes are evaluated on the falling edge from
    // values captured at the previous falling edge, which equal the values
    // present at the rising edge in between.
    initial begin : slave
        logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
        logic s_wvalid, s_wready, s_bvalid, s_bready, s_req;
        logic [3:0]  s_araddr, s_awaddr, s_wstrb;
        logic [31:0] s_wdata;
        logic r_pend, r_full, aw_seen, w_seen;
        int   aw_wait, w_wait;
        ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; viol_n = 0; req_fall_n = 0;
        aw_only_n = 0; w_only_n = 0; last_araddr = 4'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        s_arvalid = 0; s_arready = 0; s_rvalid = 0; s_rready = 0; s_awvalid = 0;
        s_awready = 0; s_wvalid = 0; s_wready = 0; s_bvalid = 0; s_bready = 0; s_req = 0;
        s_araddr = 0; s_awaddr = 0; s_wstrb = 0; s_wdata = 0;
        r_pend = 0; r_full = 0; aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                r_pend = 0; aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0;
                s_arvalid = 0; s_arready = 0; s_rvalid = 0; s_rready = 0; s_awvalid = 0;
                s_awready = 0; s_wvalid = 0; s_wready = 0; s_bvalid = 0; s_bready = 0; s_req = 0;
            end else begin
                // protocol monitor
                if (s_arvalid && !s_arready && !arvalid) viol_n++;
                if (s_awvalid && !s_awready && !awvalid) viol_n++;
                if (s_wvalid && !s_wready && !wvalid) viol_n++;
                if (s_awvalid && s_awready && awvalid) viol_n++;
                if (s_wvalid && s_wready && wvalid) viol_n++;
                if (!s_req && ((s_arvalid && s_arready) || (s_awvalid && s_awready) ||
                               (s_wvalid && s_wready))) viol_n++;
                if (s_req && !bus_req) req_fall_n++;
                if (awvalid && !wvalid) aw_only_n++;
                if (wvalid && !awvalid) w_only_n++;

                // completed handshakes
                if (s_arvalid && s_arready) begin
                    r_full = (ar_n - full_base) < full_limit;
                    ar_n++;
                    last_araddr = s_araddr;
                    r_pend = 1;
                end
                if (s_rvalid && s_rready) rvalid = 1'b0;
                if (s_awvalid && s_awready) begin
                    aw_log[aw_n & 127] = s_awaddr;
                    aw_ar_log[aw_n & 127] = ar_n;
                    aw_n++; aw_seen = 1; awready = 1'b0; aw_wait = 0;
                end
                if (s_wvalid && s_wready) begin
                    wd_log[w_n & 127] = s_wdata;
                    ws_log[w_n & 127] = s_wstrb;
                    w_n++; w_seen = 1; wready = 1'b0; w_wait = 0;
                end
                if (s_bvalid && s_bready) begin
                    bvalid = 1'b0;
                    b_n++;
                end

                // next responses
                arready = arvalid;
                if (r_pend && !rvalid) begin
                    rvalid = 1'b1;
                    rdata  = r_full ? 32'h0000_0008 : 32'h0000_0004;
                    rresp  = rresp_cfg;
                    r_pend = 0;
                end
                if (awvalid && !awready) begin
                    if (aw_wait >= aw_dly) awready = 1'b1;
                    else aw_wait++;
                end
                if (wvalid && !wready) begin
                    if (w_wait >= w_dly) wready = 1'b1;
                    else w_wait++;
                end
                if (aw_seen && w_seen && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = bresp_cfg;
                    aw_seen = 0; w_seen = 0;
                end

                s_arvalid = arvalid; s_arready = arready; s_rvalid = rvalid; s_rready = rready;
                s_awvalid = awvalid; s_awready = awready; s_wvalid = wvalid; s_wready = wready;
                s_bvalid = bvalid; s_bready = bready; s_req = bus_req;
                s_araddr = araddr; s_awaddr = awaddr; s_wstrb = wstrb; s_wdata = wdata;
            end
        end
    end

    task automatic send(input logic [4:0] id, input bit lat);
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (result_ready) begin
                ok = 1;
                break;
            end
        end
        check("ready_wait", 32'(ok), 32'd1);
        result_valid = 1'b1;
        winner_id = id;
        @(negedge clk);
        result_valid = 1'b0;
        exp_sent++;
        if (lat) begin
            check("lat_req", 32'(bus_req), 32'd1);
            check("lat_ar_early", 32'(arvalid), 32'd0);
            @(negedge clk);
            check("lat_arvalid", 32'(arvalid), 32'd1);
            check("lat_araddr", 32'(araddr), 32'h8);
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sent_count == 16'(exp_sent) && result_ready) begin
                ok = 1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_bytes(input string tag, input int id, input int base_w, input int base_aw);
        for (int k = 0; k < NB; k++) begin
            check({tag, "_wdata"}, wd_log[(base_w + k) & 127], {24'h0, exp_byte(id, k)});
            check({tag, "_wstrb"}, 32'(ws_log[(base_w + k) & 127]), 32'h1);
            check({tag, "_awaddr"}, 32'(aw_log[(base_aw + k) & 127]), 32'h4);
        end
    endtask

    initial begin : stim
        int b_ar, b_aw, b_w, b_b, b_v, b_rf, b_ao, b_wo;
        logic [31:0] ascii7 [4];
        n_cmp = 0; n_err = 0; exp_sent = 0;
        rst_n = 1'b0; bus_grant = 1'b1; result_valid = 1'b0; winner_id = 5'd0;
        aw_dly = 0; w_dly = 0; full_base = 0; full_limit = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        ascii7[0] = 32'h30; ascii7[1] = 32'h37; ascii7[2] = 32'h0D; ascii7[3] = 32'h0A;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_result_ready", 32'(result_ready), 0);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_rready", 32'(rready), 0);
        check("rst_wstrb", 32'(wstrb), 0);
        check("rst_wdata", wdata, 0);
        check("rst_addr", {24'h0, araddr, awaddr}, 0);
        check("rst_sent_count", 32'(sent_count), 0);
        check("rst_axi_err", 32'(axi_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(result_ready), 1);

        // raw-mode single result, zero-wait slave
        b_ar = ar_n; b_aw = aw_n; b_w = w_n; b_b = b_n; b_rf = req_fall_n;
        send(5'd19, 1'b1);
        wait_done("t1_done");
`ifdef ASCII_RESULT_EN
        check("t1_byte0", wd_log[b_w & 127], 32'h31);
`else
        check("t1_byte0", wd_log[b_w & 127], 32'h13);
`endif
        check_bytes("t1", 19, b_w, b_aw);
        check("t1_ar_count", 32'(ar_n - b_ar), 32'(NB));
        check("t1_araddr", 32'(last_araddr), 32'h8);
        check("t1_aw_count", 32'(aw_n - b_aw), 32'(NB));
        check("t1_b_count", 32'(b_n - b_b), 32'(NB));
        check("t1_sent_count", 32'(sent_count), 1);
        check("t1_result_ready", 32'(result_ready), 1);
        check("t1_req_falls", 32'(req_fall_n - b_rf), 32'(NB));

        // TX full for the first three STAT reads
        b_ar = ar_n; b_aw = aw_n; b_w = w_n;
        full_base = ar_n; full_limit = 3;
        send(5'd2, 1'b0);
        wait_done("t2_done");
        full_limit = 0;
        check("t2_ar_count", 32'(ar_n - b_ar), 32'(3 + NB));
        check("t2_ar_before_aw", 32'(aw_ar_log[b_aw & 127] - b_ar), 32'd4);
        check("t2_aw_count", 32'(aw_n - b_aw), 32'(NB));
        check_bytes("t2", 2, b_w, b_aw);

        // winner 7 (ASCII order when enabled), request released per byte
        b_aw = aw_n; b_w = w_n; b_rf = req_fall_n;
        send(5'd7, 1'b0);
        wait_done("t3_done");
`ifdef ASCII_RESULT_EN
        for (int k = 0; k < 4; k++) check("t3_ascii", wd_log[(b_w + k) & 127], ascii7[k]);
`else
        check("t3_raw", wd_log[b_w & 127], 32'h07);
`endif
        check("t3_req_falls", 32'(req_fall_n - b_rf), 32'(NB));
        check("t3_sent_count", 32'(sent_count), 3);

        // AWREADY late, WREADY immediate
        b_aw = aw_n; b_w = w_n; b_b = b_n; b_v = viol_n; b_ao = aw_only_n;
        aw_dly = 3; w_dly = 0;
        send(5'd10, 1'b0);
        wait_done("t4_done");
        check("t4_viol", 32'(viol_n - b_v), 0);
        check("t4_aw_held_alone", 32'(aw_only_n - b_ao > 0), 1);
        check("t4_b_count", 32'(b_n - b_b), 32'(NB));
        check_bytes("t4", 10, b_w, b_aw);

        // WREADY late, AWREADY immediate
        b_aw = aw_n; b_w = w_n; b_b = b_n; b_v = viol_n; b_wo = w_only_n;
        aw_dly = 0; w_dly = 3;
        send(5'd31, 1'b0);
        wait_done("t5_done");
        w_dly = 0;
        check("t5_viol", 32'(viol_n - b_v), 0);
        check("t5_w_held_alone", 32'(w_only_n - b_wo > 0), 1);
        check("t5_b_count", 32'(b_n - b_b), 32'(NB));
        check_bytes("t5", 31, b_w, b_aw);

        // SLVERR on write: sticky error, sequence still completes
        bresp_cfg = 2'b10;
        send(5'd3, 1'b0);
        wait_done("t6_done");
        bresp_cfg = 2'b00;
        check("t6_axi_err", 32'(axi_err), 1);
        check("t6_sent_count", 32'(sent_count), 6);
        send(5'd4, 1'b0);
        wait_done("t6b_done");
        check("t6_axi_err_sticky", 32'(axi_err), 1);

        // reset while waiting for the STAT read data
        full_base = ar_n; full_limit = 1000;
        send(5'd9, 1'b0);
        begin
            bit ok;
            ok = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (rready) begin
                    ok = 1;
                    break;
                end
            end
            check("t7_reach_stat_r", 32'(ok), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t7_rready", 32'(rready), 0);
        check("t7_arvalid", 32'(arvalid), 0);
        check("t7_bus_req", 32'(bus_req), 0);
        check("t7_result_ready", 32'(result_ready), 0);
        check("t7_sent_count", 32'(sent_count), 0);
        check("t7_axi_err", 32'(axi_err), 0);
        check("t7_araddr", 32'(araddr), 0);
        full_limit = 0;
        exp_sent = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_aw = aw_n; b_w = w_n;
        send(5'd21, 1'b0);
        wait_done("t7_done");
        check("t7_after_count", 32'(sent_count), 1);
        check_bytes("t7", 21, b_w, b_aw);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
